// File: rtl/buzz_judge_frontend.sv
// buzz_judge_frontend: input-side producer for the quiz responder.
//
// Synchronises and debounces the raw player buzzers and the host judge keys,
// arbitrates the first buzz of a round and emits player/ifCorrect/ifWrong in
// the form the scoring path consumes.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   enable_i        1 = round open, 0 = force IDLE
//   btn_player_i    raw player buzzers (active-high, asynchronous)
//   btn_ok_i        raw host "correct" key
//   btn_ng_i        raw host "wrong" key
//   player_o        one-hot owner of the current answer, else 0
//   ifCorrect_o     one-cycle pulse: owner answered correctly
//   ifWrong_o       one-cycle pulse: owner answered wrongly (or timed out)
//   locked_o        1 while a player owns the answer
//   state_o         00 IDLE, 01 ARMED, 10 LOCKED, 11 JUDGED
//
// Optional feature: define ANSWER_TIMEOUT_EN to add an answer timeout that
// judges the owner wrong after TO_CYCLES locked cycles without a host key.
module buzz_judge_frontend #(
    parameter int unsigned N_PLAYERS = 4,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_W      = 20,
    parameter int unsigned TO_CYCLES = 500000000,
    parameter int unsigned TO_W      = 29
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [N_PLAYERS-1:0] btn_player_i,
    input  logic                 btn_ok_i,
    input  logic                 btn_ng_i,
    output logic [N_PLAYERS-1:0] player_o,
    output logic                 ifCorrect_o,
    output logic                 ifWrong_o,
    output logic                 locked_o,
    output logic [1:0]           state_o
);

    // Players occupy the low bits, then ok, then ng.
    localparam int NIn = int'(N_PLAYERS) + 2;
    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StArmed  = 2'b01,
        StLocked = 2'b10,
        StJudged = 2'b11
    } state_e;

    // ---------------- Synchronisers and debouncers ----------------
    logic [NIn-1:0]            raw;
    logic [NIn-1:0]            sync1_q, sync2_q;
    logic [NIn-1:0]            db_q, db_d, db_prev_q;
    logic [NIn-1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [NIn-1:0]            rise;

    assign raw = {btn_ng_i, btn_ok_i, btn_player_i};

    // The level flips on the DB_CYCLES-th consecutive disagreeing sample;
    // any agreeing sample (or the flip itself) restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NIn; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign rise = db_q & ~db_prev_q;

    logic [N_PLAYERS-1:0] buzz_rise;
    logic                 ok_rise, ng_rise;

    assign buzz_rise = rise[N_PLAYERS-1:0];
    assign ok_rise   = rise[N_PLAYERS];
    assign ng_rise   = rise[N_PLAYERS+1];

    // Lowest-index buzzer wins a same-cycle tie.
    logic [N_PLAYERS-1:0] first_buzz;

    always_comb begin
        first_buzz = '0;
        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
            if (buzz_rise[i]) begin
                first_buzz    = '0;
                first_buzz[i] = 1'b1;
            end
        end
    end

    // ---------------- Arbitration / judgement FSM ----------------
    state_e               state_q, state_d;
    logic [N_PLAYERS-1:0] player_q, player_d;
    logic                 correct_q, correct_d;
    logic                 wrong_q, wrong_d;
    logic                 timeout;

`ifdef ANSWER_TIMEOUT_EN
    localparam logic [TO_W-1:0] ToLast = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Held at zero outside LOCKED so every lock starts from zero; saturates
    // so a cancelled ok+ng cycle at the limit still times out next cycle.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != StLocked) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != ToLast) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Any host edge in the limit cycle takes priority over the timeout.
    assign timeout = (state_q == StLocked) && (to_cnt_q == ToLast) && !ok_rise && !ng_rise;
`else
    // Timeout parameters have no hardware in this build.
    logic unused_to_cfg;
    assign unused_to_cfg = ^{TO_CYCLES, TO_W};
    assign timeout       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        if (!enable_i) begin
            state_d  = StIdle;
            player_d = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (|buzz_rise) begin
                        state_d  = StLocked;
                        player_d = first_buzz;
                    end
                end
                StLocked: begin
                    if (ok_rise && !ng_rise) begin
                        state_d   = StJudged;
                        correct_d = 1'b1;
                    end else if (ng_rise && !ok_rise) begin
                        state_d = StJudged;
                        wrong_d = 1'b1;
                    end else if (timeout) begin
                        state_d = StJudged;
                        wrong_d = 1'b1;
                    end
                end
                StJudged: begin
                    // Player was held alongside the pulse; release it now.
                    state_d  = StArmed;
                    player_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            player_q  <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
        end
    end

    assign player_o    = player_q;
    assign ifCorrect_o = correct_q;
    assign ifWrong_o   = wrong_q;
    assign locked_o    = (state_q == StLocked);
    assign state_o     = state_q;

endmodule

// File: tb/tb_buzz_judge_frontend.sv
// Self-checking bench for buzz_judge_frontend: directed scenarios followed by
// randomized button activity, compared against a behavioural model.
`timescale 1ns/1ps
module tb_buzz_judge_frontend;

    localparam int NP  = 4;
    localparam int NIN = NP + 2;
    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam int TO  = 20;
    localparam int TOW = 5;

`ifdef ANSWER_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [NP-1:0] btn_player = '0;
    logic          btn_ok = 1'b0;
    logic          btn_ng = 1'b0;
    logic [NP-1:0] player;
    logic          ifc, ifw, locked;
    logic [1:0]    state;

    buzz_judge_frontend #(
        .N_PLAYERS (NP),
        .DB_CYCLES (DB),
        .DB_W      (DBW),
        .TO_CYCLES (TO),
        .TO_W      (TOW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .btn_player_i (btn_player),
        .btn_ok_i     (btn_ok),
        .btn_ng_i     (btn_ng),
        .player_o     (player),
        .ifCorrect_o  (ifc),
        .ifWrong_o    (ifw),
        .locked_o     (locked),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- Behavioural reference model ----------------
    // Event kinds: 0 = lock, 1 = correct pulse, 2 = wrong pulse.
    typedef struct {
        int            cyc;
        int            kind;
        logic [NP-1:0] who;
    } ev_t;

    ev_t exp_q[$];

    int cyc;
    bit hist [NIN][DB+2];   // raw samples, oldest first
    bit lvl [NIN];          // debounced level
    bit lvl_prev [NIN];
    int phase;              // 0 IDLE, 1 ARMED, 2 LOCKED, 3 JUDGED
    int owner;              // -1 when nobody owns the answer
    int lock_cyc;
    bit m_ok, m_ng;

    function automatic logic [NP-1:0] onehot(input int idx);
        logic [NP-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        cyc = 0;
        phase = 0;
        owner = -1;
        lock_cyc = 0;
        m_ok = 1'b0;
        m_ng = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            lvl[i] = 1'b0;
            lvl_prev[i] = 1'b0;
            for (int j = 0; j < DB + 2; j++) hist[i][j] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit            r [NIN];
        bit            all_diff;
        int            first;
        logic [NIN-1:0] raw_now;
        cyc++;
        raw_now = {btn_ng, btn_ok, btn_player};
        for (int i = 0; i < NIN; i++) r[i] = lvl[i] && !lvl_prev[i];
        m_ok = 1'b0;
        m_ng = 1'b0;
        if (!enable) begin
            phase = 0;
            owner = -1;
        end else begin
            case (phase)
                0: phase = 1;
                1: begin
                    first = -1;
                    for (int i = NP - 1; i >= 0; i--) if (r[i]) first = i;
                    if (first >= 0) begin
                        owner = first;
                        phase = 2;
                        lock_cyc = cyc;
                        exp_q.push_back('{cyc: cyc, kind: 0, who: onehot(owner)});
                    end
                end
                2: begin
                    if (r[NP] && !r[NP+1]) begin
                        m_ok = 1'b1;
                        phase = 3;
                        exp_q.push_back('{cyc: cyc, kind: 1, who: onehot(owner)});
                    end else if (r[NP+1] && !r[NP]) begin
                        m_ng = 1'b1;
                        phase = 3;
                        exp_q.push_back('{cyc: cyc, kind: 2, who: onehot(owner)});
                    end else if (TimeoutEn && !r[NP] && !r[NP+1] && (cyc - lock_cyc) >= TO) begin
                        m_ng = 1'b1;
                        phase = 3;
                        exp_q.push_back('{cyc: cyc, kind: 2, who: onehot(owner)});
                    end
                end
                default: begin
                    phase = 1;
                    owner = -1;
                end
            endcase
        end
        // Debounced level flips when the DB synchronised samples (raw delayed
        // by two clocks) all disagree with it.
        for (int i = 0; i < NIN; i++) begin
            for (int j = 0; j < DB + 1; j++) hist[i][j] = hist[i][j+1];
            hist[i][DB+1] = raw_now[i];
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) if (hist[i][j] == lvl[i]) all_diff = 1'b0;
            lvl_prev[i] = lvl[i];
            if (all_diff) lvl[i] = !lvl[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    int ifc_seen = 0;
    int ifw_seen = 0;
    bit prev_locked = 1'b0;

    initial begin
        int  kind;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_locked = 1'b0;
                continue;
            end
            check("state", 32'(state), 32'(phase));
            check("player", 32'(player), 32'(onehot(owner)));
            check("locked", 32'(locked), 32'(phase == 2));
            check("ifCorrect", 32'(ifc), 32'(m_ok));
            check("ifWrong", 32'(ifw), 32'(m_ng));
            if (ifc) ifc_seen++;
            if (ifw) ifw_seen++;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL event_missed: kind %0d for cycle %0d not seen by cycle %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if ((locked && !prev_locked) || ifc || ifw) begin
                kind = ifc ? 1 : (ifw ? 2 : 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event_unexpected: kind %0d player %b at cycle %0d, required none",
                             kind, player, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("event_player", 32'(player), 32'(e.who));
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_locked = locked;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int c0, w0;

        // 1. Reset, then open the round.
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_player", 32'(player), 32'd0);
        check("rst_pulses", 32'({ifc, ifw}), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        tick(1);
        check("arm_state", 32'(state), 32'd1);
        tick(3);

        // 2a. Three-cycle glitch never locks.
        btn_player = 4'b0010;
        tick(3);
        btn_player = 4'b0000;
        tick(12);
        check("glitch_locked", 32'(locked), 32'd0);
        check("glitch_state", 32'(state), 32'd1);

        // 3. Simultaneous buzz: lowest index wins, later buzz ignored.
        btn_player = 4'b1010;
        tick(8);
        check("tie_player", 32'(player), 32'b0010);
        btn_player = 4'b1011;
        tick(8);
        check("late_buzz_player", 32'(player), 32'b0010);

        // 4. Host says correct.
        c0 = ifc_seen;
        btn_ok = 1'b1;
        tick(7);
        check("ok_pulse", 32'(ifc), 32'd1);
        check("ok_player", 32'(player), 32'b0010);
        check("ok_judged_state", 32'(state), 32'd3);
        tick(1);
        check("ok_after_player", 32'(player), 32'd0);
        check("ok_after_state", 32'(state), 32'd1);
        tick(2);
        check("ok_pulse_count", 32'(ifc_seen - c0), 32'd1);
        btn_ok = 1'b0;
        btn_player = 4'b0000;
        tick(10);

        // 2b. Raw-to-player latency of 3+DB_CYCLES.
        btn_player = 4'b0100;
        tick(6);
        check("latency_early_player", 32'(player), 32'd0);
        tick(1);
        check("latency_player", 32'(player), 32'b0100);
        check("latency_locked", 32'(locked), 32'd1);

        // 4b. ok and ng together cancel.
        c0 = ifc_seen;
        w0 = ifw_seen;
        btn_ok = 1'b1;
        btn_ng = 1'b1;
        tick(10);
        check("both_state", 32'(state), 32'd2);
        check("both_pulses", 32'((ifc_seen - c0) + (ifw_seen - w0)), 32'd0);
        btn_ok = 1'b0;
        btn_ng = 1'b0;
        btn_player = 4'b0000;
        tick(30);

        // 5. Enable drop while locked drops the judgement.
        btn_player = 4'b1000;
        tick(8);
        check("pre_drop_locked", 32'(locked), 32'd1);
        w0 = ifw_seen;
        enable = 1'b0;
        tick(1);
        check("drop_state", 32'(state), 32'd0);
        check("drop_player", 32'(player), 32'd0);
        enable = 1'b1;
        btn_ng = 1'b1;
        tick(10);
        check("drop_no_wrong", 32'(ifw_seen - w0), 32'd0);
        check("drop_rearmed", 32'(state), 32'd1);
        btn_ng = 1'b0;
        btn_player = 4'b0000;
        tick(10);

        // 6. Answer timeout (or its absence).
        btn_player = 4'b0010;
        tick(7);
        check("to_locked", 32'(locked), 32'd1);
        w0 = ifw_seen;
        tick(19);
        check("to_early", 32'(ifw), 32'd0);
        tick(1);
        check("to_pulse", 32'(ifw), 32'(TimeoutEn));
        tick(80);
        check("to_count", 32'(ifw_seen - w0), 32'(TimeoutEn));
        check("to_state", 32'(state), TimeoutEn ? 32'd1 : 32'd2);
        btn_player = 4'b0000;
        tick(10);

        // Randomized activity with a mid-run asynchronous reset.
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 1500; n++) begin
                @(negedge clk);
                if (!enable) enable = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 149) == 0) enable = 1'b0;
                for (int i = 0; i < NP; i++)
                    if ($urandom_range(0, 15) == 0) btn_player[i] = ~btn_player[i];
                if ($urandom_range(0, 19) == 0) btn_ok = ~btn_ok;
                if ($urandom_range(0, 19) == 0) btn_ng = ~btn_ng;
            end
            if (pass == 0) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                check("async_rst_state", 32'(state), 32'd0);
                check("async_rst_player", 32'(player), 32'd0);
                check("async_rst_pulses", 32'({ifc, ifw, locked}), 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        btn_player = '0;
        btn_ok = 1'b0;
        btn_ng = 1'b0;
        enable = 1'b1;
        tick(20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
